jtcps1_sdram_arb: RTL and testbench

- Arbitrates up to NSLOT CPS1 SDRAM clients onto one SDRAM controller port:
  - main CPU ROM
  - CPU RAM/VRAM, the only writable slot
  - scroll, palette and OBJ VRAM readers
  - GFX ROM fetchers
- Issues one request at a time and latches the returned data per slot.
- Holds each slot's ok flag for as long as that slot keeps the same address and cs asserted.
- Sits between the CPS1 video/main blocks and the SDRAM controller, and replaces ad-hoc slot sequencing.

---
 rtl/jtcps1_sdram_arb.sv | 157 +++++++++++++++
 tb/tb_jtcps1_sdram_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps1_sdram_arb.sv
// CPS1 SDRAM slot arbiter: one access in flight, per-slot data latch and sticky ok.
// Define JTCPS1_ARB_RR_EN to serve slots 1..NSLOT-1 round-robin; slot 0 always wins.
module jtcps1_sdram_arb #(
  parameter int NSLOT  = 10,
  parameter int AW     = 22,
  parameter int WRSLOT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  input  logic                slot_wr,
  input  logic [15:0]         slot_din,
  input  logic [1:0]          slot_wrmask,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [NSLOT*32-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  output logic                sdram_rnw,
  output logic [1:0]          sdram_wrmask,
  output logic [15:0]         data_write,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                refresh_en
);

  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [SW-1:0] WRSEL = SW'(WRSLOT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} t_state;

  t_state           r_state, w_state_nxt;
  logic [SW-1:0]    r_sel, w_sel;
  logic             w_hit, w_grant, w_done;
  logic [NSLOT-1:0] w_pend;
  logic [AW-1:0]    w_sel_addr;
  logic [AW-1:0]    r_last_addr [NSLOT];

  assign w_pend = slot_cs & ~slot_ok;

`ifdef JTCPS1_ARB_RR_EN
  logic [SW-1:0] r_rr;

  // r_rr holds the slot to try first; 0 or out-of-range restarts at slot 1
  always_comb begin
    int            v_base;
    logic [SW-1:0] v_idx;
    w_hit  = 1'b0;
    w_sel  = '0;
    v_base = 1;
    v_idx  = '0;
    if (r_rr != '0 && int'(r_rr) < NSLOT) v_base = int'(r_rr);
    if (w_pend[0]) begin
      w_hit = 1'b1;
    end else begin
      for (int k = 0; k < NSLOT-1; k++) begin
        v_idx = SW'((v_base - 1 + k) % (NSLOT-1) + 1);
        if (!w_hit && w_pend[v_idx]) begin
          w_hit = 1'b1;
          w_sel = v_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_rr <= '0;
    else if (w_grant) r_rr <= w_sel + 1'b1;
  end
`else
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NSLOT-1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NSLOT; i++)
      if (w_sel == SW'(i)) w_sel_addr = slot_addr[i*AW +: AW];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (!downloading && w_hit) begin
        w_grant     = 1'b1;
        w_state_nxt = ST_REQ;
      end
      ST_REQ:  if (sdram_ack) w_state_nxt = ST_WAIT;
      ST_WAIT: if (data_rdy) begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel        <= '0;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_rnw    <= 1'b1;
      sdram_wrmask <= 2'b11;
      data_write   <= '0;
      refresh_en   <= 1'b1;
    end else begin
      if (w_grant) begin
        r_sel        <= w_sel;
        sdram_req    <= 1'b1;
        sdram_addr   <= w_sel_addr;
        sdram_rnw    <= ~(w_sel == WRSEL && slot_wr);
        sdram_wrmask <= slot_wrmask;
        data_write   <= slot_din;
      end else if (r_state == ST_REQ && sdram_ack) begin
        sdram_req <= 1'b0;
      end
      if (r_state == ST_IDLE) refresh_en <= !w_grant;
    end
  end

  // ok is only granted if the slot still wants the address that was fetched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_ok   <= '0;
      slot_dout <= '0;
      for (int i = 0; i < NSLOT; i++) r_last_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (w_done && r_sel == SW'(i)) begin
          slot_ok[i]     <= slot_cs[i] && (slot_addr[i*AW +: AW] == sdram_addr);
          r_last_addr[i] <= sdram_addr;
          if (sdram_rnw) slot_dout[i*32 +: 32] <= data_read;
        end else if (!slot_cs[i] || slot_addr[i*AW +: AW] != r_last_addr[i]) begin
          slot_ok[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// Directed bench for jtcps1_sdram_arb; the round-robin order check runs only with JTCPS1_ARB_RR_EN.
module tb_jtcps1_sdram_arb;

  localparam int NSLOT = 10;
  localparam int AW    = 22;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                downloading = 1'b0;
  logic [NSLOT-1:0]    slot_cs = '0;
  logic [NSLOT*AW-1:0] slot_addr = '0;
  logic                slot_wr = 1'b0;
  logic [15:0]         slot_din = '0;
  logic [1:0]          slot_wrmask = 2'b11;
  logic [NSLOT-1:0]    slot_ok;
  logic [NSLOT*32-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_rnw;
  logic [1:0]          sdram_wrmask;
  logic [15:0]         data_write;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [31:0]         data_read = '0;
  logic                refresh_en;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int c0;
  logic req_q = 1'b0;

  jtcps1_sdram_arb #(.NSLOT(NSLOT), .AW(AW), .WRSLOT(1)) dut (
    .clk(clk), .rstn(rstn), .downloading(downloading),
    .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_wr(slot_wr),
    .slot_din(slot_din), .slot_wrmask(slot_wrmask),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_rnw(sdram_rnw),
    .sdram_wrmask(sdram_wrmask), .data_write(data_write),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sdram_req && !req_q) req_cnt++;
    req_q = sdram_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dout_of(input int i);
    return slot_dout[i*32 +: 32];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!sdram_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", sdram_req, 1'b1);
  endtask

  task automatic ack_pulse();
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
  endtask

  task automatic rdy_pulse(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy  = 1'b0;
  endtask

  task automatic complete(input logic [31:0] d);
    ack_pulse();
    tick(1);
    rdy_pulse(d);
  endtask

  initial begin
    tick(2);
    check("rst_ok", slot_ok, '0);
    check("rst_req", sdram_req, 1'b0);
    check("rst_rnw", sdram_rnw, 1'b1);
    check("rst_mask", sdram_wrmask, 2'b11);
    check("rst_refresh", refresh_en, 1'b1);
    check("rst_dout", (slot_dout == '0), 1'b1);
    rstn = 1'b1;
    tick(2);

    // single read on slot 0
    c0 = req_cnt;
    slot_cs[0] = 1'b1; set_addr(0, 22'h000123);
    wait_req();
    check("rd_addr", sdram_addr, 22'h000123);
    check("rd_rnw", sdram_rnw, 1'b1);
    check("rd_refresh", refresh_en, 1'b0);
    tick(3);
    check("rd_hold_req", sdram_req, 1'b1);
    check("rd_hold_addr", sdram_addr, 22'h000123);
    complete(32'hDEADBEEF);
    check("rd_ok", slot_ok[0], 1'b1);
    check("rd_dout", dout_of(0), 32'hDEADBEEF);
    tick(20);
    check("rd_ok_hold", slot_ok[0], 1'b1);
    check("rd_one_req", req_cnt - c0, 1);
    slot_cs[0] = 1'b0;
    tick(1);
    check("rd_ok_drop", slot_ok[0], 1'b0);

    // fixed priority: 2 before 6
    c0 = req_cnt;
    slot_cs[2] = 1'b1; set_addr(2, 22'h000200);
    slot_cs[6] = 1'b1; set_addr(6, 22'h000600);
    wait_req();
    check("pri_first", sdram_addr, 22'h000200);
    complete(32'h22222222);
    wait_req();
    check("pri_second", sdram_addr, 22'h000600);
    complete(32'h66666666);
    tick(5);
    check("pri_ok2", slot_ok[2], 1'b1);
    check("pri_ok6", slot_ok[6], 1'b1);
    check("pri_dout6", dout_of(6), 32'h66666666);
    check("pri_two_req", req_cnt - c0, 2);
    slot_cs[2] = 1'b0; slot_cs[6] = 1'b0;
    tick(1);

    // write on slot 1
    slot_cs[1] = 1'b1; set_addr(1, 22'h000100);
    slot_wr = 1'b1; slot_din = 16'h55AA; slot_wrmask = 2'b10;
    wait_req();
    check("wr_rnw", sdram_rnw, 1'b0);
    check("wr_data", data_write, 16'h55AA);
    check("wr_mask", sdram_wrmask, 2'b10);
    check("wr_addr", sdram_addr, 22'h000100);
    complete(32'hFFFFFFFF);
    check("wr_ok", slot_ok[1], 1'b1);
    check("wr_dout", dout_of(1), 32'h0);
    slot_cs[1] = 1'b0; slot_wr = 1'b0; slot_wrmask = 2'b11;
    tick(1);

    // cs dropped during WAIT
    slot_cs[3] = 1'b1; set_addr(3, 22'h000300);
    wait_req();
    ack_pulse();
    slot_cs[3] = 1'b0;
    tick(1);
    rdy_pulse(32'h33334444);
    check("abort_ok", slot_ok[3], 1'b0);
    check("abort_dout", dout_of(3), 32'h33334444);
    tick(2);
    check("abort_idle_req", sdram_req, 1'b0);
    check("abort_idle_refresh", refresh_en, 1'b1);

    // cs drop coincident with data_rdy
    slot_cs[4] = 1'b1; set_addr(4, 22'h000400);
    wait_req();
    ack_pulse();
    tick(1);
    slot_cs[4] = 1'b0;
    rdy_pulse(32'h44445555);
    check("same_ok", slot_ok[4], 1'b0);
    check("same_dout", dout_of(4), 32'h44445555);

    // slot 9 address change, plus a stray data_rdy while in REQ
    slot_cs[9] = 1'b1; set_addr(9, 22'h000010);
    wait_req();
    check("ac_addr0", sdram_addr, 22'h000010);
    data_rdy = 1'b1; data_read = 32'hBAD0BAD0;
    tick(1);
    data_rdy = 1'b0;
    check("ac_spur_req", sdram_req, 1'b1);
    check("ac_spur_ok", slot_ok[9], 1'b0);
    complete(32'h90909090);
    check("ac_ok0", slot_ok[9], 1'b1);
    check("ac_dout0", dout_of(9), 32'h90909090);
    set_addr(9, 22'h000011);
    tick(1);
    check("ac_ok_fall", slot_ok[9], 1'b0);
    wait_req();
    check("ac_addr1", sdram_addr, 22'h000011);
    complete(32'h91919191);
    check("ac_ok1", slot_ok[9], 1'b1);
    check("ac_dout1", dout_of(9), 32'h91919191);
    slot_cs[9] = 1'b0;
    tick(2);

    // stray handshakes in IDLE
    c0 = req_cnt;
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h99999999;
    tick(1);
    sdram_ack = 1'b0; data_rdy = 1'b0;
    tick(3);
    check("spur_ok", slot_ok, '0);
    check("spur_dout3", dout_of(3), 32'h33334444);
    check("spur_no_req", req_cnt - c0, 0);

    // downloading blocks new grants but lets one in flight finish
    c0 = req_cnt;
    downloading = 1'b1;
    slot_cs[0] = 1'b1; set_addr(0, 22'h000123);
    tick(10);
    check("dl_no_req", req_cnt - c0, 0);
    check("dl_refresh", refresh_en, 1'b1);
    downloading = 1'b0;
    wait_req();
    check("dl_addr", sdram_addr, 22'h000123);
    downloading = 1'b1;
    complete(32'hCAFE0000);
    check("dl_mid_ok", slot_ok[0], 1'b1);
    check("dl_mid_dout", dout_of(0), 32'hCAFE0000);
    c0 = req_cnt;
    slot_cs[7] = 1'b1; set_addr(7, 22'h000700);
    tick(5);
    check("dl_park_req", req_cnt - c0, 0);
    check("dl_park_refresh", refresh_en, 1'b1);
    slot_cs[7] = 1'b0; downloading = 1'b0;
    tick(1);

    // asynchronous reset while in WAIT
    slot_din = 16'h55AA;
    slot_cs[8] = 1'b1; set_addr(8, 22'h000800);
    wait_req();
    ack_pulse();
    #2 rstn = 1'b0;
    #1;
    check("ar_req", sdram_req, 1'b0);
    check("ar_ok", slot_ok, '0);
    check("ar_dout", (slot_dout == '0), 1'b1);
    check("ar_refresh", refresh_en, 1'b1);
    check("ar_rnw", sdram_rnw, 1'b1);
    check("ar_mask", sdram_wrmask, 2'b11);
    check("ar_addr", sdram_addr, 22'h0);
    check("ar_wdata", data_write, 16'h0);
    slot_cs = '0;
    @(negedge clk);
    rstn = 1'b1;
    tick(2);

`ifdef JTCPS1_ARB_RR_EN
    for (int i = 2; i < NSLOT; i++) begin
      slot_cs[i] = 1'b1;
      set_addr(i, AW'(22'h001000 + i));
    end
    for (int g = 0; g < 9; g++) begin
      wait_req();
      check("rr_grant", sdram_addr, (g < 8) ? AW'(22'h001002 + g) : AW'(22'h002002));
      ack_pulse();
      if (g == 0) set_addr(2, 22'h002002);
      tick(1);
      rdy_pulse(32'(g));
    end
    slot_cs = '0;
    tick(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
